pool_frame_arbiter: RTL and testbench

//  Shares one max-pool engine among NUM_CH feature producers, one whole frame at a time.

---
 rtl/pool_frame_arbiter_pkg.sv | 18 +
 rtl/pool_frame_arbiter_rr_arbiter.sv | 26 ++
 rtl/pool_frame_arbiter.sv | 129 ++++++++++++
 tb/tb_pool_frame_arbiter.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pool_frame_arbiter_pkg.sv
// pool_frame_arbiter_pkg: shared pixel type, arbiter FSM states and width helper
package pool_frame_arbiter_pkg;

    localparam int FEAT_W = 8;

    typedef logic [FEAT_W-1:0] feature_type;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DRAIN
    } pool_arb_state_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pool_frame_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick starting just after the last grant
module rr_arbiter
    import pool_frame_arbiter_pkg::*;
#(
    parameter int N    = 4,
    parameter int CH_W = idx_width(N)
) (
    input  logic [N-1:0]    i_req,
    input  logic [CH_W-1:0] i_last,
    output logic [CH_W-1:0] o_gnt_idx,
    output logic            o_any_req
);

    // Walk offsets from farthest to nearest so the nearest requester after i_last wins
    always_comb begin
        o_gnt_idx = '0;
        o_any_req = 1'b0;
        for (int i = N; i >= 1; i--)
            for (int c = 0; c < N; c++)
                if (i_req[c] && c == (int'(i_last) + i) % N) begin
                    o_gnt_idx = CH_W'(c);
                    o_any_req = 1'b1;
                end
    end

endmodule

// File: rtl/pool_frame_arbiter.sv
// pool_frame_arbiter: frame-locked round-robin sharing of one max-pool engine
module pool_frame_arbiter
    import pool_frame_arbiter_pkg::*;
#(
    parameter  int NUM_CH       = 4,
    parameter  int IMAGE_HEIGHT = 4,
    parameter  int IMAGE_WIDTH  = 4,
    parameter  int ROW_STRIDE   = 2,
    parameter  int COL_STRIDE   = 2,
    localparam int CH_W         = idx_width(NUM_CH)
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic [NUM_CH-1:0]        i_ch_in_valid,
    output logic [NUM_CH-1:0]        o_ch_in_ready,
    input  logic [NUM_CH*FEAT_W-1:0] i_ch_in_data,
    output logic [NUM_CH-1:0]        o_ch_out_valid,
    input  logic [NUM_CH-1:0]        i_ch_out_ready,
    output logic [FEAT_W-1:0]        o_ch_out_data,
    output logic                     o_pool_in_valid,
    input  logic                     i_pool_in_ready,
    output logic [FEAT_W-1:0]        o_pool_in_data,
    input  logic                     i_pool_out_valid,
    output logic                     o_pool_out_ready,
    input  logic [FEAT_W-1:0]        i_pool_out_data,
    output logic                     o_busy,
    output logic [CH_W-1:0]          o_active_ch,
    output logic [15:0]              o_frames_done
);

    localparam int IN_BEATS  = IMAGE_HEIGHT * IMAGE_WIDTH;
    localparam int OUT_BEATS = (IMAGE_HEIGHT / ROW_STRIDE) * (IMAGE_WIDTH / COL_STRIDE);
    localparam int CNT_W     = $clog2(IN_BEATS + 1);

    if (NUM_CH < 1 || IMAGE_HEIGHT % ROW_STRIDE != 0 || IMAGE_WIDTH % COL_STRIDE != 0) begin : g_bad_params
        $error("pool_frame_arbiter: NUM_CH must be >= 1 and frame dims divisible by strides");
    end

    pool_arb_state_t r_state, w_state_nxt;
    logic [CH_W-1:0]   r_active_ch, r_last_grant, w_gnt_idx;
    logic [CNT_W-1:0]  r_in_cnt, r_out_cnt;
    logic [15:0]       r_frames_done;
    logic              w_any_req, w_load, w_drain;
    logic              w_sel_in_valid, w_sel_out_ready;
    feature_type       w_sel_in_data;
    logic [NUM_CH-1:0] w_onehot;
    logic              w_in_hs, w_out_hs, w_in_last, w_out_last;

    rr_arbiter #(.N(NUM_CH), .CH_W(CH_W)) u_rr (
        .i_req     (i_ch_in_valid),
        .i_last    (r_last_grant),
        .o_gnt_idx (w_gnt_idx),
        .o_any_req (w_any_req)
    );

    // Select the granted channel's request-side signals and build its one-hot mask
    always_comb begin
        w_onehot        = '0;
        w_sel_in_valid  = 1'b0;
        w_sel_in_data   = '0;
        w_sel_out_ready = 1'b0;
        for (int c = 0; c < NUM_CH; c++)
            if (CH_W'(c) == r_active_ch) begin
                w_onehot[c]     = 1'b1;
                w_sel_in_valid  = i_ch_in_valid[c];
                w_sel_in_data   = i_ch_in_data[c*FEAT_W +: FEAT_W];
                w_sel_out_ready = i_ch_out_ready[c];
            end
    end

    assign w_load     = r_state == LOAD;
    assign w_drain    = r_state == DRAIN;
    assign w_in_hs    = w_load & w_sel_in_valid & i_pool_in_ready;
    assign w_out_hs   = w_drain & i_pool_out_valid & w_sel_out_ready;
    assign w_in_last  = w_in_hs & (r_in_cnt == CNT_W'(IN_BEATS - 1));
    assign w_out_last = w_out_hs & (r_out_cnt == CNT_W'(OUT_BEATS - 1));

    // Next state and the handshake routing; everything is silent outside the owning phase
    always_comb begin
        w_state_nxt      = r_state;
        o_pool_in_valid  = w_load & w_sel_in_valid;
        o_pool_in_data   = w_load ? w_sel_in_data : '0;
        o_ch_in_ready    = (w_load & i_pool_in_ready) ? w_onehot : '0;
        o_ch_out_valid   = (w_drain & i_pool_out_valid) ? w_onehot : '0;
        o_pool_out_ready = w_drain & w_sel_out_ready;
        o_ch_out_data    = w_drain ? i_pool_out_data : '0;
        o_busy           = r_state != IDLE;
        case (r_state)
            IDLE:    w_state_nxt = w_any_req ? LOAD : IDLE;
            LOAD:    w_state_nxt = w_in_last ? DRAIN : LOAD;
            DRAIN:   w_state_nxt = w_out_last ? IDLE : DRAIN;
            default: w_state_nxt = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    // Grant capture, beat counters, fairness pointer and frame counter
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_active_ch   <= '0;
            r_last_grant  <= CH_W'(NUM_CH - 1);
            r_in_cnt      <= '0;
            r_out_cnt     <= '0;
            r_frames_done <= '0;
        end else begin
            if (r_state == IDLE && w_any_req)
                r_active_ch <= w_gnt_idx;
            if (w_in_hs)
                r_in_cnt <= w_in_last ? '0 : r_in_cnt + 1'b1;
            if (w_out_hs)
                r_out_cnt <= w_out_last ? '0 : r_out_cnt + 1'b1;
            if (w_out_last) begin
                r_last_grant  <= r_active_ch;
                r_frames_done <= r_frames_done + 16'd1;
            end
        end
    end

    assign o_active_ch   = r_active_ch;
    assign o_frames_done = r_frames_done;

endmodule

// File: tb/tb_pool_frame_arbiter.sv
// tb_pool_frame_arbiter: scoreboard bench with a behavioural 2x2 max-pool engine
module tb_pool_frame_arbiter;
    import pool_frame_arbiter_pkg::*;

    localparam int NCH   = 4;
    localparam int W     = 4;
    localparam int IN_B  = 16;
    localparam int OUT_B = 4;

    logic                  clock = 1'b0;
    logic                  reset_n = 1'b0;
    logic [NCH-1:0]        ch_in_valid, ch_in_ready, ch_out_valid, ch_out_ready;
    logic [NCH*FEAT_W-1:0] ch_in_data;
    logic [FEAT_W-1:0]     ch_out_data, pool_in_data, pool_out_data;
    logic                  pool_in_valid, pool_in_ready, pool_out_valid, pool_out_ready, busy;
    logic [1:0]            active_ch;
    logic [15:0]           frames_done;

    pool_frame_arbiter dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .i_ch_in_valid    (ch_in_valid),
        .o_ch_in_ready    (ch_in_ready),
        .i_ch_in_data     (ch_in_data),
        .o_ch_out_valid   (ch_out_valid),
        .i_ch_out_ready   (ch_out_ready),
        .o_ch_out_data    (ch_out_data),
        .o_pool_in_valid  (pool_in_valid),
        .i_pool_in_ready  (pool_in_ready),
        .o_pool_in_data   (pool_in_data),
        .i_pool_out_valid (pool_out_valid),
        .o_pool_out_ready (pool_out_ready),
        .i_pool_out_data  (pool_out_data),
        .o_busy           (busy),
        .o_active_ch      (active_ch),
        .o_frames_done    (frames_done)
    );

    always #5 clock = ~clock;

    int bq[NCH][$];
    int exp_q[NCH][$];
    int grant_q[$];
    int beat[NCH];
    int eng_buf[IN_B];
    int ein, eout, exp_frames, cyc, end_cyc, out_n;
    int n_chk, n_pass;
    bit ephase, stall, chk_grant, gap_chk, end_pend, prev_busy;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic int win_max(input int o);
        int m = 0;
        for (int r = 0; r < 2; r++)
            for (int k = 0; k < 2; k++)
                if (eng_buf[((o / (W/2))*2 + r)*W + (o % (W/2))*2 + k] > m)
                    m = eng_buf[((o / (W/2))*2 + r)*W + (o % (W/2))*2 + k];
        return m;
    endfunction

    // frame of pixels base..base+15 in raster order pools to base+{5,7,13,15}
    task automatic enqueue(input int c, input int base);
        bq[c].push_back(base);
        exp_q[c].push_back(base + 5);
        exp_q[c].push_back(base + 7);
        exp_q[c].push_back(base + 13);
        exp_q[c].push_back(base + 15);
        exp_frames++;
    endtask

    task automatic drive();
        for (int c = 0; c < NCH; c++) begin
            ch_in_valid[c] = (bq[c].size() > 0) && (!stall || ($urandom % 2) == 0);
            ch_in_data[c*FEAT_W +: FEAT_W] = (bq[c].size() > 0) ? FEAT_W'(bq[c][0] + beat[c]) : '0;
            ch_out_ready[c] = !stall || ($urandom % 10) >= 3;
        end
        pool_in_ready  = !ephase && (!stall || ($urandom % 2) == 0);
        pool_out_valid = ephase;
        pool_out_data  = ephase ? FEAT_W'(win_max(eout)) : '0;
    endtask

    task automatic tick();
        logic [NCH-1:0] ihs;
        bit ehi, eho;
        int pd;
        @(negedge clock);
        ihs = ch_in_valid & ch_in_ready;
        ehi = pool_in_valid & pool_in_ready;
        eho = pool_out_valid & pool_out_ready;
        pd  = int'(pool_in_data);
        @(posedge clock);
        #1;
        for (int c = 0; c < NCH; c++)
            if (ihs[c]) begin
                beat[c]++;
                if (beat[c] == IN_B) begin
                    beat[c] = 0;
                    void'(bq[c].pop_front());
                end
            end
        if (eho) begin
            eout++;
            if (eout == OUT_B) begin ephase = 0; ein = 0; eout = 0; end
        end
        if (ehi) begin
            eng_buf[ein] = pd;
            ein++;
            if (ein == IN_B) begin ephase = 1; eout = 0; end
        end
        drive();
    endtask

    task automatic check_zero(input string name);
        check({name, "_ctl"}, int'({busy, pool_in_valid, pool_out_ready, ch_in_ready, ch_out_valid, active_ch}), 0);
        check({name, "_data"}, int'({pool_in_data, ch_out_data}), 0);
        check({name, "_frames"}, int'(frames_done), 0);
    endtask

    task automatic do_reset(input string name);
        reset_n = 1'b0;
        for (int c = 0; c < NCH; c++) begin
            bq[c].delete();
            exp_q[c].delete();
            beat[c] = 0;
        end
        grant_q.delete();
        ein = 0; eout = 0; ephase = 0; exp_frames = 0; gap_chk = 0;
        drive();
        #1;
        check_zero(name);
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
    endtask

    function automatic bit pending();
        bit p = busy || ephase;
        for (int c = 0; c < NCH; c++)
            if (bq[c].size() > 0 || exp_q[c].size() > 0) p = 1;
        return p;
    endfunction

    task automatic wait_done(input string name, input int budget);
        int n = 0;
        while (pending() && n < budget) begin
            tick();
            n++;
        end
        check({name, "_complete"}, int'(pending()), 0);
        check({name, "_frames_done"}, int'(frames_done), exp_frames & 16'hFFFF);
    endtask

    initial forever @(posedge clock) cyc++;

    // scoreboard monitor: per-cycle lock checks, grant order and pooled data
    initial begin
        logic [NCH-1:0] oh;
        forever begin
            @(negedge clock);
            if (!reset_n) begin
                prev_busy = 0;
                out_n = 0;
                end_pend = 0;
            end else begin
                oh = 4'b0001 << active_ch;
                if (!busy) check("idle_quiet", int'({ch_in_ready, ch_out_valid, pool_in_valid, pool_out_ready}), 0);
                else check("frame_lock", int'((ch_in_ready | ch_out_valid) & ~oh), 0);
                if (end_pend && cyc == end_cyc + 1) begin
                    check("busy_drop", int'(busy), 0);
                    end_pend = 0;
                end
                if (busy && !prev_busy) begin
                    if (gap_chk) begin
                        check("grant_gap", cyc - end_cyc, 2);
                        gap_chk = 0;
                    end
                    if (chk_grant) begin
                        if (grant_q.size() == 0) check("grant_unexpected", int'(active_ch), -1);
                        else check("grant_order", int'(active_ch), grant_q.pop_front());
                    end
                end
                prev_busy = busy;
                for (int c = 0; c < NCH; c++)
                    if (ch_out_valid[c] && ch_out_ready[c]) begin
                        if (exp_q[c].size() == 0) check($sformatf("out_unexpected_ch%0d", c), int'(ch_out_data), -1);
                        else check($sformatf("out_data_ch%0d", c), int'(ch_out_data), exp_q[c].pop_front());
                        out_n++;
                        if (out_n == OUT_B) begin
                            out_n = 0;
                            end_cyc = cyc;
                            end_pend = 1;
                        end
                    end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        ch_in_valid = '0; ch_in_data = '0; ch_out_ready = '0;
        pool_in_ready = 0; pool_out_valid = 0; pool_out_data = '0;
        stall = 0; chk_grant = 1;
        do_reset("reset");
        // single channel, pixels 1..16
        enqueue(1, 1);
        grant_q.push_back(1);
        drive();
        wait_done("t1", 400);
        check("t1_one_frame", int'(frames_done), 1);
        // all channels requesting from reset
        do_reset("t2_reset");
        enqueue(0, 20); enqueue(1, 40); enqueue(2, 60); enqueue(3, 80); enqueue(0, 100);
        grant_q = '{0, 1, 2, 3, 0};
        drive();
        wait_done("t2", 1000);
        // late request from ch2 during ch0 LOAD beat 7
        do_reset("t3_reset");
        enqueue(0, 120);
        grant_q.push_back(0);
        drive();
        n = 0;
        while (beat[0] < 7 && n < 200) begin tick(); n++; end
        check("t3_reach_beat7", beat[0], 7);
        enqueue(2, 140);
        grant_q.push_back(2);
        gap_chk = 1;
        drive();
        wait_done("t3", 400);
        // random stalls on both sides
        chk_grant = 0;
        stall = 1;
        do_reset("t4_reset");
        enqueue(0, 160); enqueue(1, 180); enqueue(2, 200); enqueue(3, 220); enqueue(1, 1);
        drive();
        wait_done("t4", 4000);
        stall = 0;
        chk_grant = 1;
        // reset in the middle of a ch3 frame
        do_reset("t5_pre");
        enqueue(3, 30);
        grant_q.push_back(3);
        drive();
        n = 0;
        while (beat[3] < 9 && n < 200) begin tick(); n++; end
        check("t5_reach_beat9", beat[3], 9);
        do_reset("t5_midframe");
        enqueue(0, 50); enqueue(3, 70);
        grant_q = '{0, 3};
        drive();
        wait_done("t5", 600);
        // frame counter wrap
        force dut.r_frames_done = 16'hFFFF;
        #1;
        release dut.r_frames_done;
        check("t6_preload", int'(frames_done), 16'hFFFF);
        exp_frames = 16'hFFFF;
        enqueue(1, 90);
        grant_q.push_back(1);
        drive();
        wait_done("t6", 400);
        check("t6_wrap", int'(frames_done), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
